// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory read bus and decode handshake between sequencer and its neighbours
interface pc_sequencer_if #(
   parameter int ADDR_W  = 11,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_data;
   logic               dec_valid;
   logic [INSTR_W-1:0] dec_instr;
   logic               dec_ready;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr,
      input  imem_valid, imem_data, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr,
      output imem_valid, imem_data, dec_ready
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/issue/PC-update sequencer resolving BR, BZ and HLT
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_sequencer #(
   parameter int       ADDR_W         = 11,
   parameter int       INSTR_W        = 16,
   parameter bit [4:0] OPC_BR         = 5'b11000,
   parameter bit [4:0] OPC_BZ         = 5'b11001,
   parameter bit [4:0] OPC_HLT        = 5'b11111,
   parameter int       TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] current_addr,
   input  logic              zero_flag,
   pc_sequencer_if.master    bus,
   output logic              inc,
   output logic              branch_en,
   output logic [ADDR_W-1:0] branch_addr,
   output logic              halt,
   output logic [15:0]       retire_cnt,
   output logic              fetch_err
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_UPD,
      S_HALT
   } state_t;

   state_t             state, state_d;
   logic [INSTR_W-1:0] ir, ir_d;
   logic               req_q, req_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               dv_q, dv_d;
   logic               inc_q, inc_d;
   logic               br_q, br_d;
   logic [ADDR_W-1:0]  baddr_q, baddr_d;
   logic               halt_q, halt_d;
   logic [15:0]        retire_q, retire_d;
   logic [4:0]         opcode;

   assign opcode = ir[INSTR_W-1:INSTR_W-5];

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] wait_cnt, wait_cnt_d;
   logic       err_q, err_d;
`endif

   // Every output is the registered image of the next-state decision, so
   // a pulse chosen in ISSUE becomes visible during UPD.
   always_comb begin
      state_d  = state;
      ir_d     = ir;
      req_d    = 1'b0;
      addr_d   = addr_q;
      dv_d     = 1'b0;
      inc_d    = 1'b0;
      br_d     = 1'b0;
      baddr_d  = baddr_q;
      halt_d   = halt_q;
      retire_d = retire_q;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_d = wait_cnt;
      err_d      = err_q;
`endif
      case (state)
         S_FETCH: begin
            req_d   = 1'b1;
            addr_d  = current_addr;
            state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_d = 4'd0;
`endif
         end
         S_WAIT: begin
            if (bus.imem_valid) begin
               ir_d    = bus.imem_data;
               dv_d    = 1'b1;
               state_d = S_ISSUE;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wait_cnt == 4'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               halt_d  = 1'b1;
               state_d = S_HALT;
            end else begin
               wait_cnt_d = wait_cnt + 4'd1;
            end
`endif
         end
         S_ISSUE: begin
            dv_d = 1'b1;
            if (dv_q && bus.dec_ready) begin
               dv_d     = 1'b0;
               retire_d = retire_q + 16'd1;
               if (opcode == OPC_HLT) begin
                  halt_d  = 1'b1;
                  state_d = S_HALT;
               end else if (opcode == OPC_BR || (opcode == OPC_BZ && zero_flag)) begin
                  br_d    = 1'b1;
                  baddr_d = ir[ADDR_W-1:0];
                  state_d = S_UPD;
               end else begin
                  inc_d   = 1'b1;
                  state_d = S_UPD;
               end
            end
         end
         S_UPD: begin
            state_d = S_FETCH;
         end
         S_HALT: begin
            halt_d = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         ir       <= '0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         dv_q     <= 1'b0;
         inc_q    <= 1'b0;
         br_q     <= 1'b0;
         baddr_q  <= '0;
         halt_q   <= 1'b0;
         retire_q <= 16'd0;
      end else begin
         state    <= state_d;
         ir       <= ir_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         dv_q     <= dv_d;
         inc_q    <= inc_d;
         br_q     <= br_d;
         baddr_q  <= baddr_d;
         halt_q   <= halt_d;
         retire_q <= retire_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt_d;
         err_q    <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.dec_valid = dv_q;
   assign bus.dec_instr = ir;
   assign inc           = inc_q;
   assign branch_en     = br_q;
   assign branch_addr   = baddr_q;
   assign halt          = halt_q;
   assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
// Memory answers in the cycle its request is visible; a small PC register closes the loop.
module tb_pc_sequencer;

   localparam int K_INC  = 0;
   localparam int K_BR   = 1;
   localparam int K_HALT = 2;

   logic        clk;
   logic        rst;
   logic        zero_flag;
   logic        dec_ready;
   logic        mem_auto;
   logic        man_valid;
   logic [15:0] man_data;
   logic [10:0] pc;
   logic        inc;
   logic        branch_en;
   logic [10:0] branch_addr;
   logic        halt;
   logic [15:0] retire_cnt;
   logic        fetch_err;
   logic [15:0] rom [0:2047];
   logic [15:0] exp_retire;
   int          vectors;
   int          miscompares;
   int          n;

   pc_sequencer_if #(.ADDR_W(11), .INSTR_W(16)) bus ();

   pc_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .current_addr (pc),
      .zero_flag    (zero_flag),
      .bus          (bus),
      .inc          (inc),
      .branch_en    (branch_en),
      .branch_addr  (branch_addr),
      .halt         (halt),
      .retire_cnt   (retire_cnt),
      .fetch_err    (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.imem_valid = mem_auto ? bus.imem_req : man_valid;
      bus.imem_data  = mem_auto ? rom[bus.imem_addr] : man_data;
   end
   assign bus.dec_ready = dec_ready;

   always_ff @(posedge clk) begin
      if (rst)
         pc <= 11'd0;
      else if (branch_en)
         pc <= branch_addr;
      else if (inc)
         pc <= pc + 11'd1;
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(output int cnt);
      cnt = 0;
      do begin
         tick;
         cnt++;
      end while (bus.imem_req !== 1'b1 && cnt < 32);
      check("fetch_req", {31'd0, bus.imem_req}, 32'd1);
   endtask

   task automatic run_instr(input logic [10:0] a, input logic [15:0] ins, input int kind,
                            input logic [10:0] ba, input int period);
      int c;
      wait_req(c);
      if (period > 0) check("fetch_period", c + 2, period);
      check("fetch_addr", bus.imem_addr, a);
      tick;
      check("issue_valid", bus.dec_valid, 1);
      check("issue_instr", bus.dec_instr, ins);
      check("issue_no_pulse", {inc, branch_en}, 0);
      tick;
      exp_retire++;
      check("retire_cnt", retire_cnt, exp_retire);
      check("pulse_inc", inc, kind == K_INC);
      check("pulse_branch", branch_en, kind == K_BR);
      check("pulse_halt", halt, kind == K_HALT);
      check("dec_valid_drop", bus.dec_valid, 0);
      if (kind == K_BR) check("branch_addr", branch_addr, ba);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_retire  = 16'd0;
      for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
      rom[11'h005] = 16'hC07F;
      rom[11'h07F] = 16'hC810;
      rom[11'h080] = 16'hC810;
      rom[11'h010] = 16'h1234;
      rom[11'h011] = 16'hC7FF;
      rst       = 1'b1;
      zero_flag = 1'b0;
      dec_ready = 1'b1;
      mem_auto  = 1'b1;
      man_valid = 1'b0;
      man_data  = 16'h0000;
      repeat (3) tick;

      check("rst_imem_req", bus.imem_req, 0);
      check("rst_imem_addr", bus.imem_addr, 0);
      check("rst_dec_valid", bus.dec_valid, 0);
      check("rst_dec_instr", bus.dec_instr, 0);
      check("rst_pulses", {inc, branch_en, halt}, 0);
      check("rst_branch_addr", branch_addr, 0);
      check("rst_retire", retire_cnt, 0);
      check("rst_fetch_err", fetch_err, 0);
      rst = 1'b0;

      run_instr(11'h000, 16'h0000, K_INC, 11'h000, 0);
      run_instr(11'h001, 16'h0000, K_INC, 11'h000, 4);
      run_instr(11'h002, 16'h0000, K_INC, 11'h000, 4);
      check("retire_after_3", retire_cnt, 3);
      run_instr(11'h003, 16'h0000, K_INC, 11'h000, 4);
      run_instr(11'h004, 16'h0000, K_INC, 11'h000, 4);
      run_instr(11'h005, 16'hC07F, K_BR, 11'h07F, 4);

      zero_flag = 1'b0;
      run_instr(11'h07F, 16'hC810, K_INC, 11'h000, 4);
      zero_flag = 1'b1;
      run_instr(11'h080, 16'hC810, K_BR, 11'h010, 4);
      zero_flag = 1'b0;

      // decode stall: dec_ready low for five ISSUE cycles
      dec_ready = 1'b0;
      wait_req(n);
      check("stall_fetch_addr", bus.imem_addr, 11'h010);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("stall_valid", bus.dec_valid, 1);
         check("stall_instr", bus.dec_instr, 16'h1234);
         check("stall_no_pulse", {inc, branch_en}, 0);
         check("stall_retire", retire_cnt, exp_retire);
      end
      tick;
      dec_ready = 1'b1;
      check("stall_still_valid", bus.dec_valid, 1);
      tick;
      exp_retire++;
      check("stall_pulse", {inc, branch_en}, 2'b10);
      check("stall_retire_inc", retire_cnt, exp_retire);
      tick;
      check("stall_single_pulse", {inc, branch_en}, 0);

      run_instr(11'h011, 16'hC7FF, K_BR, 11'h7FF, 0);
      run_instr(11'h7FF, 16'h0000, K_INC, 11'h000, 4);
      wait_req(n);
      check("wrap_fetch_addr", bus.imem_addr, 0);
      check("retire_before_rst", retire_cnt, 11);

      rst = 1'b1;
      tick;
      tick;
      check("mid_rst_retire", retire_cnt, 0);
      check("mid_rst_outputs", {bus.imem_req, bus.dec_valid, inc, branch_en, halt}, 0);
      rom[0] = 16'hF800;
      exp_retire = 16'd0;
      rst = 1'b0;

      run_instr(11'h000, 16'hF800, K_HALT, 11'h000, 0);
      mem_auto = 1'b0;
      for (int i = 0; i < 20; i++) begin
         man_valid = i[0];
         man_data  = 16'h0000;
         tick;
         check("halt_level", halt, 1);
         check("halt_no_req", bus.imem_req, 0);
         check("halt_quiet", {bus.dec_valid, inc, branch_en}, 0);
      end
      check("halt_retire", retire_cnt, 1);

      man_valid = 1'b0;
      rst = 1'b1;
      tick;
      check("halt_rst_halt", halt, 0);
      check("halt_rst_addr", bus.imem_addr, 0);
      rom[0] = 16'h0000;
      rst = 1'b0;

      // reset while WAIT holds a pending read, stale data arrives next cycle
      wait_req(n);
      check("wait_fetch_addr", bus.imem_addr, 0);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      man_valid = 1'b1;
      man_data  = 16'hBEEF;
      check("wait_rst_quiet", {bus.imem_req, bus.dec_valid}, 0);
      tick;
      check("refetch_req", bus.imem_req, 1);
      check("refetch_addr", bus.imem_addr, 0);
      man_valid = 1'b0;
      mem_auto  = 1'b1;
      tick;
      check("refetch_valid", bus.dec_valid, 1);
      check("refetch_instr", bus.dec_instr, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
      rst = 1'b1;
      tick;
      rst = 1'b0;
      mem_auto  = 1'b0;
      man_valid = 1'b0;
      wait_req(n);
      repeat (14) tick;
      check("wd_not_yet", {fetch_err, halt}, 0);
      tick;
      check("wd_fetch_err", fetch_err, 1);
      check("wd_halt", halt, 1);
`else
      check("fetch_err_tied", fetch_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
